// File: rtl/nor_and_arbiter.sv
// Round-robin time-sharing of one (a+b)'.c evaluator among N requesters.
// Each operation takes arbitrate -> evaluate -> respond, one edge per step.

module sub_circuit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d
);
  assign d = c & ~(a | b);
endmodule

module nor_and_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    a_in,
  input  logic [N-1:0]    b_in,
  input  logic [N-1:0]    c_in,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic            resp_valid,
  output logic [ID_W-1:0] resp_id,
  output logic            result
);
  // state | meaning
  // IDLE  | no operation in flight; arbitrates on the edge a req is seen
  // EVAL  | operands registered, shared evaluator output settling
  // RESP  | resp_valid pulse; round-robin pointer advances on exit
  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t          state, state_nxt;
  logic            op_a, op_b, op_c, d;
  logic [ID_W-1:0] sel_id, last, sel, idx;
  logic            found;

  // First pending requester after the last one served, wrapping modulo N.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = ID_W'((int'(last) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  sub_circuit u_eval (
    .a(op_a),
    .b(op_b),
    .c(op_c),
    .d(d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      result     <= 1'b0;
      op_a       <= 1'b0;
      op_b       <= 1'b0;
      op_c       <= 1'b0;
      sel_id     <= '0;
      last       <= ID_W'(N - 1);
    end else begin
      case (state)
        IDLE: if (found) begin
          grant  <= N'(1) << sel;
          op_a   <= a_in[sel];
          op_b   <= b_in[sel];
          op_c   <= c_in[sel];
          sel_id <= sel;
        end
        EVAL: begin
          result     <= d;
          resp_id    <= sel_id;
          resp_valid <= 1'b1;
        end
        RESP: begin
          resp_valid <= 1'b0;
          grant      <= '0;
          last       <= sel_id;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
endmodule
